inst_realign_buffer: RTL

Parametrised fetch realigner for the RV32IC front end, between instruction memory and decode. It holds fetched halfwords in a small circular queue, assembles 16- and 32-bit instructions at any halfword alignment (including 32-bit instructions that straddle fetch words) and emits one instruction per cycle with its PC. Redirects from jumps and branches flush the queue and restart fetch at a halfword-aligned target without stalling the PC for an extra cycle.

---
 rtl/inst_realign_buffer_if.sv | 26 ++
 rtl/inst_realign_buffer.sv | 138 +++++++++++++
 2 files changed

// File: rtl/inst_realign_buffer_if.sv
// Fetch-beat and decoded-instruction handshakes of the realign buffer.
// master is the realigner itself; slave is the memory/decode environment around it.
interface inst_realign_buffer_if #(
  parameter int XLEN     = 32,
  parameter int FETCH_HW = 2
);
  logic [XLEN-1:0]         fetch_addr;
  logic                    fetch_valid;
  logic                    fetch_ready;
  logic [16*FETCH_HW-1:0]  fetch_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [31:0]             out_inst;
  logic [XLEN-1:0]         out_pc;
  logic                    out_is_c;

  modport master (
    output fetch_addr, fetch_ready, out_valid, out_inst, out_pc, out_is_c,
    input  fetch_valid, fetch_data, out_ready
  );

  modport slave (
    input  fetch_addr, fetch_ready, out_valid, out_inst, out_pc, out_is_c,
    output fetch_valid, fetch_data, out_ready
  );
endinterface

// File: rtl/inst_realign_buffer.sv
// RV32IC fetch realigner: circular halfword queue that emits one 16/32-bit
// instruction per cycle with its PC, restarting cleanly on redirects.
module inst_realign_buffer #(
  parameter int              XLEN     = 32,
  parameter int              FETCH_HW = 2,
  parameter int              BUF_HW   = 4,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [XLEN-1:0]        flush_pc,
  inst_realign_buffer_if.master  bus
);

  localparam int PW = (BUF_HW > 1) ? $clog2(BUF_HW) : 1;
  localparam int CW = $clog2(BUF_HW + 1);
  localparam int SW = (FETCH_HW > 1) ? $clog2(FETCH_HW) : 1;
  localparam logic [XLEN-1:0] BEAT_MASK = XLEN'(2 * FETCH_HW - 1);

  // Pointer arithmetic modulo BUF_HW; n never exceeds BUF_HW so one wrap suffices.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] ptr, input logic [PW:0] n);
    logic [PW+1:0] sum;
    sum = {2'b00, ptr} + {1'b0, n};
    if (sum >= (PW+2)'(BUF_HW)) begin
      sum = sum - (PW+2)'(BUF_HW);
    end else begin
      sum = sum;
    end
    return sum[PW-1:0];
  endfunction

  function automatic logic [SW-1:0] skip_of(input logic [XLEN-1:0] addr);
    return SW'((addr & BEAT_MASK) >> 1);
  endfunction

  logic [15:0]      buf_r [BUF_HW];
  logic [PW-1:0]    head_r;
  logic [PW-1:0]    tail_r;
  logic [CW-1:0]    count_r;
  logic [SW-1:0]    skip_r;
  logic [XLEN-1:0]  pc_r;
  logic [XLEN-1:0]  faddr_r;

  logic [15:0]      h0_s;
  logic [15:0]      h1_s;
  logic             is_c_s;
  logic [PW:0]      need_s;
  logic [PW:0]      pushed_s;
  logic             push_s;
  logic             pop_s;
  logic [CW-1:0]    count_next_s;
  logic [BUF_HW-1:0] wr_en_s;
  logic [15:0]      wr_data_s [BUF_HW];

  // Head decode, handshakes and next occupancy, all from registered state.
  always_comb begin
    h0_s     = buf_r[head_r];
    h1_s     = buf_r[ptr_add(head_r, (PW+1)'(1))];
    is_c_s   = (h0_s[1:0] != 2'b11);
    need_s   = is_c_s ? (PW+1)'(1) : (PW+1)'(2);
    pushed_s = (PW+1)'(FETCH_HW) - (PW+1)'(skip_r);

    bus.out_valid   = (count_r >= CW'(need_s)) && !flush;
    bus.out_inst    = is_c_s ? {16'h0000, h0_s} : {h1_s, h0_s};
    bus.out_is_c    = is_c_s;
    bus.out_pc      = pc_r;
    bus.fetch_addr  = faddr_r;
    // No same-cycle pop credit: space is judged on the registered count only.
    bus.fetch_ready = (count_r <= CW'(BUF_HW - FETCH_HW)) && !flush;

    push_s = bus.fetch_valid && bus.fetch_ready;
    pop_s  = bus.out_valid && bus.out_ready;

    count_next_s = count_r
                 + (push_s ? CW'(pushed_s) : {CW{1'b0}})
                 - (pop_s  ? CW'(need_s)   : {CW{1'b0}});
  end

  // Scatter the kept halfwords of an accepted beat (index >= skip) to slots from the tail.
  always_comb begin
    for (int j = 0; j < BUF_HW; j++) begin
      wr_en_s[j]   = 1'b0;
      wr_data_s[j] = 16'h0000;
      for (int i = 0; i < FETCH_HW; i++) begin
        logic hit;
        hit = push_s && (i >= int'(skip_r))
              && (ptr_add(tail_r, (PW+1)'(i) - (PW+1)'(skip_r)) == PW'(j));
        wr_en_s[j]   = wr_en_s[j] | hit;
        wr_data_s[j] = hit ? bus.fetch_data[16*i +: 16] : wr_data_s[j];
      end
    end
  end

  // Halfword storage; contents are only meaningful where count says so.
  always_ff @(posedge clk) begin
    for (int j = 0; j < BUF_HW; j++) begin
      if (wr_en_s[j]) begin
        buf_r[j] <= wr_data_s[j];
      end
    end
  end

  // Queue control, PC and fetch address; flush outranks push and pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
      pc_r    <= RESET_PC & ~XLEN'(1);
      faddr_r <= RESET_PC & ~BEAT_MASK;
      skip_r  <= skip_of(RESET_PC);
    end else if (flush) begin
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
      pc_r    <= flush_pc & ~XLEN'(1);
      faddr_r <= flush_pc & ~BEAT_MASK;
      skip_r  <= skip_of(flush_pc);
    end else begin
      if (push_s) begin
        tail_r  <= ptr_add(tail_r, pushed_s);
        faddr_r <= faddr_r + XLEN'(2 * FETCH_HW);
        skip_r  <= {SW{1'b0}};
      end else begin
        tail_r  <= tail_r;
      end
      if (pop_s) begin
        head_r <= ptr_add(head_r, need_s);
        pc_r   <= pc_r + (is_c_s ? XLEN'(2) : XLEN'(4));
      end else begin
        head_r <= head_r;
      end
      count_r <= count_next_s;
    end
  end

endmodule
